mem_access_ctrl: RTL and testbench

Sequencing stage directly downstream of the CPU's 4:1 address-select multiplexer. It latches the selected address (plus write data and direction) on a request and drives one memory access with a fixed, parameterised number of wait states. It then returns read data with a one-cycle completion pulse. Every instruction fetch and load/store goes through this block to reach memory.

---
 rtl/mem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//
// Sequencing stage between the CPU address-select mux and memory. A request
// accepted while idle latches address, write data and direction, then drives
// one memory access lasting WAIT_STATES+1 cycles (or longer, until mem_ack,
// when the acknowledge option is built in). After the access it gives a
// one-cycle done pulse. Read data is held on rdata_out until the next read
// completes.
//
// Optional feature macro: MEM_CTRL_ACK_EN
//   defined   -> mem_ack input exists; ACCESS exits only when the wait
//                counter has reached 0 and mem_ack=1 on the same edge.
//   undefined -> fixed-latency access, no mem_ack port.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset
//   req        in   access request, taken only while ready=1
//   we         in   1=write, 0=read, sampled with req
//   addr_in    in   address from the address-select mux
//   wdata_in   in   write data, sampled with req
//   ready      out  idle, can accept a request
//   done       out  one-cycle completion pulse
//   rdata_out  out  last read data
//   mem_en     out  memory enable, high for the whole access
//   mem_we     out  memory write strobe
//   mem_addr   out  latched access address
//   mem_wdata  out  latched write data
//   mem_rdata  in   memory read data
//   mem_ack    in   memory acknowledge (MEM_CTRL_ACK_EN only)

module mem_access_ctrl #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int WAIT_STATES       = 2   // legal range 0..15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req,
  input  logic                         we,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr_in,
  input  logic [DATA_BUS_WIDTH-1:0]    wdata_in,
  output logic                         ready,
  output logic                         done,
  output logic [DATA_BUS_WIDTH-1:0]    rdata_out,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_rdata
`ifdef MEM_CTRL_ACK_EN
  ,
  input  logic                         mem_ack
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t                         state_q, state_d;
  logic [3:0]                     cnt_q, cnt_d;
  logic [ADDRESS_BUS_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0]      wdata_q, wdata_d;
  logic                           we_q, we_d;
  logic [DATA_BUS_WIDTH-1:0]      rdata_q, rdata_d;

  // Memory-side permission to finish the access once the counter is spent.
  logic ack_ok;
`ifdef MEM_CTRL_ACK_EN
  assign ack_ok = mem_ack;
`else
  assign ack_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr_in;
          wdata_d = wdata_in;
          we_d    = we;
          cnt_d   = WAIT_LOAD;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Testing for zero first means the counter can never wrap; in ack
        // mode it simply sits at zero until the acknowledge arrives.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (ack_ok) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // All handshake outputs decode registered state only, so req never
  // reaches them combinationally.
  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = (state_q == ST_ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed scenarios plus randomized traffic
// against a simple memory device and an expected-contents array.

module tb_mem_access_ctrl;

`ifdef MEM_CTRL_ACK_EN
  localparam int WS = 0;
`else
  localparam int WS = 2;
`endif
  localparam int P = WS + 3;   // request-to-request period

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] addr_in;
  logic [15:0] wdata_in;
  logic        ready;
  logic        done;
  logic [15:0] rdata_out;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
`ifdef MEM_CTRL_ACK_EN
  logic        mem_ack;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected rdata_out as tracked by the bench across scenarios.
  logic [15:0] exp_rdata;

  // Memory device: preloaded pattern, writable only while use_mem=1.
  logic        use_mem;
  logic [15:0] rdata_force;
  logic [15:0] dev_mem [64];
  bit          dev_wr  [64];
  logic [5:0]  dev_idx;

  function automatic logic [15:0] preload(input logic [5:0] a);
    return 16'hA000 ^ {a, a, 4'h5};
  endfunction

  assign dev_idx   = mem_addr[5:0];
  assign mem_rdata = use_mem ? (dev_wr[dev_idx] ? dev_mem[dev_idx] : preload(dev_idx))
                             : rdata_force;

  always @(posedge clk) begin
    if (use_mem && mem_en && mem_we) begin
      dev_mem[dev_idx] <= mem_wdata;
      dev_wr[dev_idx]  <= 1'b1;
    end
  end

  mem_access_ctrl #(
    .ADDRESS_BUS_WIDTH(16),
    .DATA_BUS_WIDTH(16),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .we(we),
    .addr_in(addr_in),
    .wdata_in(wdata_in),
    .ready(ready),
    .done(done),
    .rdata_out(rdata_out),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_CTRL_ACK_EN
    ,
    .mem_ack(mem_ack)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if ({ready, done, mem_en, mem_we, rdata_out, mem_addr, mem_wdata} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0}) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: rdy/done/en/we=%b%b%b%b rdata=%h addr=%h wdata=%h, required 1000 0000 0000 0000",
                 i, ready, done, mem_en, mem_we, rdata_out, mem_addr, mem_wdata);
      end
      tick();
    end
    exp_rdata = 16'h0;
    $display("[TB] reset: idle held 10 cycles");
  endtask

  task automatic test_read();
    use_mem     = 1'b0;
    rdata_force = 16'hBEEF;
    req = 1'b1; we = 1'b0; addr_in = 16'h0040; wdata_in = 16'h5555;
    tick();
    req = 1'b0;
    for (int s = 1; s <= WS + 3; s++) begin
      tests_run++;
      if ({ready, done, mem_en} !== {s == WS + 3, s == WS + 2, s <= WS + 1}) begin
        tests_failed++;
        $display("FAIL read_timing s=%0d: rdy/done/en=%b%b%b, required %b%b%b",
                 s, ready, done, mem_en, s == WS + 3, s == WS + 2, s <= WS + 1);
      end
      if (s <= WS + 1) begin
        tests_run++;
        if ({mem_addr, mem_we} !== {16'h0040, 1'b0}) begin
          tests_failed++;
          $display("FAIL read_bus s=%0d: addr=%h we=%b, required 0040 0", s, mem_addr, mem_we);
        end
      end else begin
        tests_run++;
        if (rdata_out !== 16'hBEEF) begin
          tests_failed++;
          $display("FAIL read_data s=%0d: rdata=%h, required beef", s, rdata_out);
        end
      end
      tick();
    end
    exp_rdata = 16'hBEEF;
    $display("[TB] read addr=0040 rdata=%h", rdata_out);
  endtask

  task automatic test_write();
    int done_cnt = 0;
    use_mem     = 1'b0;
    rdata_force = 16'h7777;
    req = 1'b1; we = 1'b1; addr_in = 16'h0100; wdata_in = 16'h1234;
    tick();
    req = 1'b0; addr_in = 16'hFFFF; wdata_in = 16'h0000; we = 1'b0;
    for (int s = 1; s <= WS + 5; s++) begin
      if (done) done_cnt++;
      if (s <= WS + 1) begin
        tests_run++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0100, 16'h1234}) begin
          tests_failed++;
          $display("FAIL write_bus s=%0d: en=%b we=%b addr=%h wdata=%h, required 1 1 0100 1234",
                   s, mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      tests_run++;
      if (rdata_out !== exp_rdata) begin
        tests_failed++;
        $display("FAIL write_rdata_hold s=%0d: rdata=%h, required %h", s, rdata_out, exp_rdata);
      end
      tick();
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL write_done_count: %0d pulses, required 1", done_cnt);
    end
    $display("[TB] write addr=0100 wdata=1234 done_pulses=%0d", done_cnt);
  endtask

  task automatic test_back_to_back();
    use_mem     = 1'b0;
    rdata_force = 16'h0F0F;
    req = 1'b1; we = 1'b0; addr_in = 16'h0022;
    for (int i = 0; i < 4 * P; i++) begin
      tests_run++;
      if ({ready, done, mem_en} !== {(i % P) == 0, (i % P) == WS + 2,
                                     ((i % P) >= 1) && ((i % P) <= WS + 1)}) begin
        tests_failed++;
        $display("FAIL busy_reject cycle %0d: rdy/done/en=%b%b%b, required %b%b%b",
                 i, ready, done, mem_en, (i % P) == 0, (i % P) == WS + 2,
                 ((i % P) >= 1) && ((i % P) <= WS + 1));
      end
      if (i == 4 * P - 1) req = 1'b0;
      tick();
    end
    exp_rdata = 16'h0F0F;
    $display("[TB] back-to-back: 4 accesses with req held high, period %0d", P);
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    use_mem     = 1'b0;
    rdata_force = 16'hC3C3;
`ifdef MEM_CTRL_ACK_EN
    mem_ack = 1'b0;
`endif
    req = 1'b1; we = 1'b0; addr_in = 16'h0033;
    tick();
    req = 1'b1;   // still asserted: reset must win
    tick();       // second ACCESS cycle
    reset = 1'b1;
    tick();
    tests_run++;
    if ({ready, done, mem_en, rdata_out} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      tests_failed++;
      $display("FAIL reset_mid: rdy/done/en=%b%b%b rdata=%h, required 100 0000",
               ready, done, mem_en, rdata_out);
    end
    reset = 1'b0; req = 1'b0;
`ifdef MEM_CTRL_ACK_EN
    mem_ack = 1'b1;
`endif
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      tick();
    end
    tests_run++;
    if (done_cnt !== 0 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: %0d pulses ready=%b, required 0 pulses ready=1", done_cnt, ready);
    end
    exp_rdata = 16'h0;
    $display("[TB] reset mid-access: aborted, done pulses=%0d", done_cnt);
  endtask

`ifdef MEM_CTRL_ACK_EN
  task automatic test_ack();
    use_mem     = 1'b0;
    rdata_force = 16'h1111;
    mem_ack = 1'b0;
    req = 1'b1; we = 1'b0; addr_in = 16'h0044;
    tick();
    req = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      tests_run++;
      if ({mem_en, done} !== 2'b10) begin
        tests_failed++;
        $display("FAIL ack_wait s=%0d: en=%b done=%b, required 1 0", s, mem_en, done);
      end
      if (s == 4) begin
        mem_ack = 1'b1;
        rdata_force = 16'h00A5;
      end
      if (s < 4) tick();
    end
    tick();
    tests_run++;
    if ({done, mem_en, rdata_out} !== {1'b1, 1'b0, 16'h00A5}) begin
      tests_failed++;
      $display("FAIL ack_done: done=%b en=%b rdata=%h, required 1 0 00a5", done, mem_en, rdata_out);
    end
    tick();
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_ready: ready=%b, required 1", ready);
    end
    exp_rdata = 16'h00A5;
    $display("[TB] ack mode read rdata=%h", rdata_out);
  endtask
`endif

  task automatic test_random();
    logic [15:0] exp_mem [64];
    bit          exp_wr  [64];
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_new;
    logic [5:0]  ix;
    use_mem = 1'b1;
    for (int t = 0; t < 24; t++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = 16'($urandom);
      r_wdata = 16'($urandom);
      ix      = r_addr[5:0];
      if (r_we) begin
        r_new      = exp_rdata;
        exp_mem[ix] = r_wdata;
        exp_wr[ix]  = 1'b1;
      end else begin
        r_new = exp_wr[ix] ? exp_mem[ix] : preload(ix);
      end
      req = 1'b1; we = r_we; addr_in = r_addr; wdata_in = r_wdata;
      tick();
      req = 1'b0; we = ~r_we; addr_in = 16'($urandom); wdata_in = 16'($urandom);
      for (int s = 1; s <= WS + 3; s++) begin
        tests_run++;
        if ({ready, done, mem_en} !== {s == WS + 3, s == WS + 2, s <= WS + 1}) begin
          tests_failed++;
          $display("FAIL rand_timing t=%0d s=%0d: rdy/done/en=%b%b%b, required %b%b%b",
                   t, s, ready, done, mem_en, s == WS + 3, s == WS + 2, s <= WS + 1);
        end
        if (s <= WS + 1) begin
          tests_run++;
          if ({mem_addr, mem_we} !== {r_addr, r_we} || (r_we && mem_wdata !== r_wdata)) begin
            tests_failed++;
            $display("FAIL rand_bus t=%0d s=%0d: addr=%h we=%b wdata=%h, required %h %b %h",
                     t, s, mem_addr, mem_we, mem_wdata, r_addr, r_we, r_wdata);
          end
        end
        tests_run++;
        if (rdata_out !== ((s <= WS + 1) ? exp_rdata : r_new)) begin
          tests_failed++;
          $display("FAIL rand_rdata t=%0d s=%0d: rdata=%h, required %h",
                   t, s, rdata_out, (s <= WS + 1) ? exp_rdata : r_new);
        end
        tick();
      end
      exp_rdata = r_new;
      $display("[TB] rand t=%0d %s addr=%h wdata=%h rdata_out=%h", t, r_we ? "WR" : "RD",
               r_addr, r_wdata, rdata_out);
      repeat ($urandom_range(0, 2)) tick();
    end
    use_mem = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr_in = '0; wdata_in = '0;
    use_mem = 1'b0; rdata_force = '0; exp_rdata = '0;
`ifdef MEM_CTRL_ACK_EN
    mem_ack = 1'b1;
`endif
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_CTRL_ACK_EN
    test_ack();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
